// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial two's-complement subtractor, diff = a - b.
// One bit per clock, LSB first, with a borrow flop and start/busy/done control.
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      request, accepted when busy=0 (IDLE or DONE cycle)
//   a, b       minuend / subtrahend, captured on the accepting edge
//   busy       high while an operation is in progress
//   done       single-cycle pulse, results valid from this cycle
//   diff       a - b modulo 2^WIDTH
//   borrow_out unsigned borrow (a < b)
//   overflow   signed overflow of a - b
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             overflow
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] r_sh;
    logic [CW-1:0]    cnt;
    logic             borrow;
    logic             a_msb;
    logic             b_msb;

    logic             x;
    logic             y;
    logic             d;
    logic             borrow_nx;
    logic [WIDTH-1:0] r_nx;

    assign x         = a_sh[0];
    assign y         = b_sh[0];
    assign d         = x ^ y ^ borrow;
    assign borrow_nx = (~x & y) | (~(x ^ y) & borrow);
    // New bit enters at the MSB; after WIDTH shifts r_nx holds the full word.
    assign r_nx      = WIDTH'({d, r_sh} >> 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            a_sh       <= '0;
            b_sh       <= '0;
            r_sh       <= '0;
            cnt        <= '0;
            borrow     <= 1'b0;
            a_msb      <= 1'b0;
            b_msb      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        a_sh   <= a;
                        b_sh   <= b;
                        r_sh   <= '0;
                        borrow <= 1'b0;
                        cnt    <= '0;
                        a_msb  <= a[WIDTH-1];
                        b_msb  <= b[WIDTH-1];
                        busy   <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    r_sh   <= r_nx;
                    borrow <= borrow_nx;
                    cnt    <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        diff       <= r_nx;
                        borrow_out <= borrow_nx;
                        // Signs differ and the result sign left the minuend's.
                        overflow   <= (a_msb ^ b_msb) & (d ^ a_msb);
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh   <= a;
                        b_sh   <= b;
                        r_sh   <= '0;
                        borrow <= 1'b0;
                        cnt    <= '0;
                        a_msb  <= a[WIDTH-1];
                        b_msb  <= b[WIDTH-1];
                        busy   <= 1'b1;
                        state  <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed bench for serial_subtractor (WIDTH 8 and 2).
// A timeline/arithmetic model is compared against both instances every cycle.
module tb_serial_subtractor;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;

    logic       start8 = 1'b0;
    logic [7:0] a8 = '0;
    logic [7:0] b8 = '0;
    logic       busy8, done8, bo8, ov8;
    logic [7:0] diff8;

    logic       start2 = 1'b0;
    logic [1:0] a2 = '0;
    logic [1:0] b2 = '0;
    logic       busy2, done2, bo2, ov2;
    logic [1:0] diff2;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .diff(diff8),
        .borrow_out(bo8), .overflow(ov8)
    );

    serial_subtractor #(.WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2),
        .busy(busy2), .done(done2), .diff(diff2),
        .borrow_out(bo2), .overflow(ov2)
    );

    task automatic check(input string name, input longint act, input longint exp);
        n_assert++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int exp_diff(input int a, input int b, input int w);
        return (a - b) & ((1 << w) - 1);
    endfunction

    function automatic logic exp_ov(input int a, input int b, input int w);
        int h, sa, sb, sd;
        h  = 1 << (w - 1);
        sa = (a >= h) ? a - 2 * h : a;
        sb = (b >= h) ? b - 2 * h : b;
        sd = sa - sb;
        return (sd < -h) || (sd >= h);
    endfunction

    // Model: an accepted request releases its arithmetic result WIDTH edges later.
    int   m_left [2] = '{0, 0};
    logic m_busy [2] = '{0, 0};
    logic m_done [2] = '{0, 0};
    int   m_diff [2] = '{0, 0};
    logic m_bo   [2] = '{0, 0};
    logic m_ov   [2] = '{0, 0};
    int   p_diff [2] = '{0, 0};
    logic p_bo   [2] = '{0, 0};
    logic p_ov   [2] = '{0, 0};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_left[i] <= 0;
                m_busy[i] <= 0;
                m_done[i] <= 0;
                m_diff[i] <= 0;
                m_bo[i]   <= 0;
                m_ov[i]   <= 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                int   w, ia, ib;
                logic st;
                w  = (i == 0) ? 8 : 2;
                ia = (i == 0) ? int'(a8) : int'(a2);
                ib = (i == 0) ? int'(b8) : int'(b2);
                st = (i == 0) ? start8 : start2;
                if (m_busy[i]) begin
                    m_left[i] <= m_left[i] - 1;
                    if (m_left[i] == 1) begin
                        m_busy[i] <= 0;
                        m_done[i] <= 1;
                        m_diff[i] <= p_diff[i];
                        m_bo[i]   <= p_bo[i];
                        m_ov[i]   <= p_ov[i];
                    end
                end else begin
                    m_done[i] <= 0;
                    if (st) begin
                        m_busy[i] <= 1;
                        m_left[i] <= w;
                        p_diff[i] <= exp_diff(ia, ib, w);
                        p_bo[i]   <= (ia < ib);
                        p_ov[i]   <= exp_ov(ia, ib, w);
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        check("busy8", busy8, m_busy[0]);
        check("done8", done8, m_done[0]);
        check("diff8", diff8, m_diff[0]);
        check("borrow8", bo8, m_bo[0]);
        check("ovf8", ov8, m_ov[0]);
        check("busy2", busy2, m_busy[1]);
        check("done2", done2, m_done[1]);
        check("diff2", diff2, m_diff[1]);
        check("borrow2", bo2, m_bo[1]);
        check("ovf2", ov2, m_ov[1]);
    end

    task automatic wait_done(input int i, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!((i == 0) ? done8 : done2) && n < 40);
        if (!((i == 0) ? done8 : done2))
            check("done_timeout", 0, 1);
    endtask

    task automatic count_dones(input int cycles, output int c);
        c = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (done8) c++;
        end
    endtask

    task automatic run8(input string name, input int a, input int b,
                        input int ed, input int ebo, input int eov);
        int n;
        @(negedge clk);
        a8 = 8'(a);
        b8 = 8'(b);
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        wait_done(0, n);
        check({name, "_lat"}, n, 8);
        check({name, "_diff"}, diff8, ed);
        check({name, "_bo"}, bo8, ebo);
        check({name, "_ov"}, ov8, eov);
    endtask

    int d2_tab [16] = '{0, 3, 2, 1, 1, 0, 3, 2, 2, 1, 0, 3, 3, 2, 1, 0};
    logic [15:0] bo2_tab = 16'h08CE;
    logic [15:0] ov2_tab = 16'h02C4;

    initial begin
        int n, c;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy8, 0);
        check("rst_done", done8, 0);
        check("rst_diff", diff8, 0);
        rst_n = 1'b1;

        run8("t100_37", 100, 37, 63, 0, 0);
        run8("t5_9", 5, 9, 8'hFC, 1, 0);
        run8("t80_01", 8'h80, 8'h01, 8'h7F, 0, 1);
        run8("t7f_ff", 8'h7F, 8'hFF, 8'h80, 1, 1);

        // start held high; second operand pair presented in the DONE cycle
        @(negedge clk);
        a8 = 8'd20;
        b8 = 8'd3;
        start8 = 1'b1;
        wait_done(0, n);
        check("held1_diff", diff8, 17);
        check("held1_bo", bo8, 0);
        a8 = 8'd3;
        b8 = 8'd20;
        wait_done(0, n);
        check("held_gap", n, 9);
        check("held2_diff", diff8, 8'hEF);
        check("held2_bo", bo8, 1);
        start8 = 1'b0;
        count_dones(12, c);
        check("held_extra_done", c, 0);

        // start pulsed mid-run with new operands must be ignored
        @(negedge clk);
        a8 = 8'd200;
        b8 = 8'd1;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (2) @(negedge clk);
        a8 = 8'd0;
        b8 = 8'd0;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        wait_done(0, n);
        check("midstart_diff", diff8, 199);
        count_dones(12, c);
        check("midstart_extra_done", c, 0);

        // asynchronous reset in the middle of an operation
        @(negedge clk);
        a8 = 8'd50;
        b8 = 8'd7;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", busy8, 0);
        check("arst_done", done8, 0);
        check("arst_diff", diff8, 0);
        check("arst_bo", bo8, 0);
        check("arst_ov", ov8, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        count_dones(15, c);
        check("arst_no_done", c, 0);
        run8("t9_9", 9, 9, 0, 0, 0);

        // WIDTH=2: all operand pairs, issued back to back
        @(negedge clk);
        a2 = 2'd0;
        b2 = 2'd0;
        start2 = 1'b1;
        for (int k = 0; k < 16; k++) begin
            wait_done(1, n);
            check("w2_lat", n, 3);
            check("w2_diff", diff2, d2_tab[k]);
            check("w2_bo", bo2, bo2_tab[k]);
            check("w2_ov", ov2, ov2_tab[k]);
            if (k < 15) begin
                a2 = 2'((k + 1) >> 2);
                b2 = 2'((k + 1) & 3);
            end else begin
                start2 = 1'b0;
            end
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
